// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed 16x16 MULT/DIV sequencer driving an external adder, results to HI/LO.
// Optional overflow flag enabled by defining MULDIV_OV_FLAG_EN; otherwise ov is tied low.
module muldiv_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero,
  output logic             ov,
  output logic [WIDTH-1:0] adder_x,
  output logic [WIDTH-1:0] adder_y,
  output logic             adder_op,
  output logic             adder_cin,
  input  logic [WIDTH-1:0] adder_out,
  input  logic             adder_cout
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] r_reg;     // MULT: P_hi, DIV: partial remainder
  logic [WIDTH-1:0] q_reg;     // MULT: P_lo, DIV: quotient (starts as |a|)
  logic [WIDTH-1:0] m_reg;     // operand added/subtracted each step
  logic             div_reg, neg_res_reg, neg_rem_reg, dz_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg;
  logic             done_reg, div_zero_reg;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               b_zero;
  logic [WIDTH:0]     r_sh;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, dz_hi;

  assign mag_a  = a[WIDTH-1] ? -a : a;
  assign mag_b  = b[WIDTH-1] ? -b : b;
  assign b_zero = (b == '0);
  assign r_sh   = {r_reg, q_reg[WIDTH-1]};

  assign prod     = {r_reg, q_reg};
  assign prod_fix = neg_res_reg ? -prod : prod;
  assign quo_fix  = neg_res_reg ? -q_reg : q_reg;
  assign rem_fix  = neg_rem_reg ? -r_reg : r_reg;
  assign dz_hi    = neg_rem_reg ? -q_reg : q_reg;   // restores the original a

  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign hi       = hi_reg;
  assign lo       = lo_reg;
  assign div_zero = div_zero_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    adder_x    = '0;
    adder_y    = '0;
    adder_op   = 1'b0;
    adder_cin  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = (op_div && b_zero) ? FIXUP : RUN;
      end
      RUN: begin
        if (cnt_reg == CW'(WIDTH-1)) state_next = FIXUP;
        if (div_reg) begin
          adder_x   = r_sh[WIDTH-1:0];
          adder_y   = m_reg;
          adder_op  = 1'b1;
          adder_cin = 1'b1;
        end else begin
          adder_x = r_reg;
          adder_y = q_reg[0] ? m_reg : '0;
        end
      end
      FIXUP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg      <= '0;
      r_reg        <= '0;
      q_reg        <= '0;
      m_reg        <= '0;
      div_reg      <= 1'b0;
      neg_res_reg  <= 1'b0;
      neg_rem_reg  <= 1'b0;
      dz_reg       <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            div_reg      <= op_div;
            neg_res_reg  <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_rem_reg  <= a[WIDTH-1];
            dz_reg       <= op_div && b_zero;
            r_reg        <= '0;
            q_reg        <= op_div ? mag_a : mag_b;
            m_reg        <= op_div ? mag_b : mag_a;
            cnt_reg      <= '0;
            div_zero_reg <= 1'b0;
          end
        end
        RUN: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (div_reg) begin
            // Restoring step: keep the difference only when it did not borrow
            if (r_sh[WIDTH] | adder_cout) begin
              r_reg <= adder_out;
              q_reg <= {q_reg[WIDTH-2:0], 1'b1};
            end else begin
              r_reg <= r_sh[WIDTH-1:0];
              q_reg <= {q_reg[WIDTH-2:0], 1'b0};
            end
          end else begin
            r_reg <= {adder_cout, adder_out[WIDTH-1:1]};
            q_reg <= {adder_out[0], q_reg[WIDTH-1:1]};
          end
        end
        FIXUP: begin
          done_reg     <= 1'b1;
          div_zero_reg <= dz_reg;
          if (dz_reg) begin
            hi_reg <= dz_hi;
            lo_reg <= '1;
          end else if (div_reg) begin
            hi_reg <= rem_fix;
            lo_reg <= quo_fix;
          end else begin
            hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
            lo_reg <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MULDIV_OV_FLAG_EN
  logic ov_reg, ov_calc;

  // Only a positive quotient of magnitude 2^(WIDTH-1) can overflow a divide
  assign ov_calc = dz_reg  ? 1'b0 :
                   div_reg ? (!neg_res_reg && q_reg[WIDTH-1]) :
                   (prod_fix[2*WIDTH-1:WIDTH] != {WIDTH{prod_fix[WIDTH-1]}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    ov_reg <= 1'b0;
    else if (state_reg == FIXUP) ov_reg <= ov_calc;
  end

  assign ov = ov_reg;
`else
  assign ov = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: arithmetic reference model plus per-cycle compare and directed vectors.
module tb_muldiv_sequencer;
`ifdef MULDIV_OV_FLAG_EN
  localparam bit OV_EN = 1'b1;
`else
  localparam bit OV_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        start = 1'b0, op_div = 1'b0;
  logic [15:0] in_a = '0, in_b = '0;
  logic        busy, done, div_zero, ov;
  logic [15:0] hi, lo, adder_x, adder_y, adder_out;
  logic        adder_op, adder_cin, adder_cout;
  logic [16:0] adder_sum;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  // External adder: x + (op ? ~y : y) + cin
  assign adder_sum  = {1'b0, adder_x} + {1'b0, (adder_op ? ~adder_y : adder_y)} + {16'b0, adder_cin};
  assign adder_out  = adder_sum[15:0];
  assign adder_cout = adder_sum[16];

  muldiv_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op_div(op_div), .a(in_a), .b(in_b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero), .ov(ov),
    .adder_x(adder_x), .adder_y(adder_y), .adder_op(adder_op), .adder_cin(adder_cin),
    .adder_out(adder_out), .adder_cout(adder_cout)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference result from plain signed arithmetic: {div_zero, ov, hi, lo}
  function automatic logic [33:0] model(input logic d, input logic [15:0] ma, input logic [15:0] mb);
    int sa, sb, p, qq, rr;
    logic [15:0] h, l;
    logic z, o;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    z = 1'b0;
    if (!d) begin
      p = sa * sb;
      h = p[31:16];
      l = p[15:0];
      o = (p != int'($signed(l)));
    end else if (sb == 0) begin
      h = ma;
      l = 16'hFFFF;
      z = 1'b1;
      o = 1'b0;
    end else begin
      qq = sa / sb;
      rr = sa % sb;
      h = rr[15:0];
      l = qq[15:0];
      o = (qq > 32767) || (qq < -32768);
    end
    return {z, o & OV_EN, h, l};
  endfunction

  // Model: cycles remaining until done, pending result, visible result
  int          m_left;
  logic        m_done, m_div;
  logic [33:0] m_pend;
  logic [15:0] e_hi, e_lo;
  logic        e_dz, e_ov;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0; m_done <= 1'b0; m_div <= 1'b0; m_pend <= '0;
      e_hi <= '0; e_lo <= '0; e_dz <= 1'b0; e_ov <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          {e_dz, e_ov, e_hi, e_lo} <= m_pend;
        end
      end else if (start) begin
        m_pend <= model(op_div, in_a, in_b);
        m_left <= (op_div && in_b == 16'h0) ? 1 : 17;
        m_div  <= op_div;
        e_dz   <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", 32'(busy), 32'(m_left != 0));
      chk("done", 32'(done), 32'(m_done));
      chk("hi", 32'(hi), 32'(e_hi));
      chk("lo", 32'(lo), 32'(e_lo));
      chk("div_zero", 32'(div_zero), 32'(e_dz));
      chk("ov", 32'(ov), 32'(e_ov));
      if (m_left >= 2) begin
        chk("run_adder_op", 32'(adder_op), 32'(m_div));
        chk("run_adder_cin", 32'(adder_cin), 32'(m_div));
      end else begin
        chk("idle_adder_x", 32'(adder_x), 32'h0);
        chk("idle_adder_y", 32'(adder_y), 32'h0);
        chk("idle_adder_ctl", 32'({adder_op, adder_cin}), 32'h0);
      end
    end
  end

  // Counts edges after the sampling edge until done is seen (17 normal, 1 for divide by zero)
  task automatic wait_done(output int k);
    k = 0;
    forever begin
      @(negedge clk);
      if (k == 0) chk("dz_clear_on_accept", 32'(div_zero), 32'h0);
      if (done) break;
      if (k >= 40) begin
        chk("done_timeout", 32'(k), 32'h11);
        break;
      end
      k++;
    end
  endtask

  task automatic issue(input logic d, input logic [15:0] ta, input logic [15:0] tb2);
    @(negedge clk);
    op_div = d; in_a = ta; in_b = tb2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic d, input logic [15:0] ta, input logic [15:0] tb2,
                        input logic [15:0] xh, input logic [15:0] xl, input logic xdz,
                        input logic xov, input int xlat);
    int k;
    issue(d, ta, tb2);
    wait_done(k);
    chk({nm, "_latency"}, 32'(k), 32'(xlat));
    chk({nm, "_hi"}, 32'(hi), 32'(xh));
    chk({nm, "_lo"}, 32'(lo), 32'(xl));
    chk({nm, "_dz"}, 32'(div_zero), 32'(xdz));
    chk({nm, "_ov"}, 32'(ov), 32'(xov));
    $display("%s: a=%h b=%h div=%0b -> hi=%h lo=%h dz=%0b ov=%0b edges=%0d", nm, ta, tb2, d, hi, lo, div_zero, ov, k);
  endtask

  initial begin
    int k;
    #3;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_hilo", 32'({hi, lo}), 32'h0);
    chk("rst_flags", 32'({div_zero, ov}), 32'h0);
    chk("rst_adder", 32'({adder_x, adder_y, adder_op, adder_cin}), 32'h0);
    @(negedge clk); #2 rst = 1'b0;

    run_op("mult_3_m4",    1'b0, 16'h0003, 16'hFFFC, 16'hFFFF, 16'hFFF4, 1'b0, 1'b0,  17);
    run_op("mult_max",     1'b0, 16'h7FFF, 16'h7FFF, 16'h3FFF, 16'h0001, 1'b0, OV_EN, 17);
    run_op("div_m7_2",     1'b1, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0, 1'b0,  17);
    run_op("div_zero",     1'b1, 16'h0064, 16'h0000, 16'h0064, 16'hFFFF, 1'b1, 1'b0,  1);
    run_op("div_wrap",     1'b1, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, OV_EN, 17);
    run_op("mult_min_sq",  1'b0, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0, OV_EN, 17);
    run_op("div_m100_7",   1'b1, 16'hFF9C, 16'h0007, 16'hFFFE, 16'hFFF2, 1'b0, 1'b0,  17);
    run_op("div_pos_min",  1'b1, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000, 1'b0, 1'b0,  17);
    run_op("mult_zero",    1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b0,  17);

    // Second start during RUN cycle 4 must be dropped
    issue(1'b0, 16'h0123, 16'h0045);
    repeat (3) @(negedge clk);
    op_div = 1'b1; in_a = 16'hFFFF; in_b = 16'hFFFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(k);
    chk("ignored_start_hi", 32'(hi), 32'h0000);
    chk("ignored_start_lo", 32'(lo), 32'h4E6F);
    @(negedge clk);
    chk("ignored_start_not_queued", 32'(busy), 32'h0);
    $display("ignored_start: hi=%h lo=%h", hi, lo);

    // Reset during RUN cycle 8
    issue(1'b0, 16'h1234, 16'h5678);
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_hilo", 32'({hi, lo}), 32'h0);
    @(negedge clk); #2 rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) chk("midrst_no_done", 32'(done), 32'h0);
    end
    chk("midrst_idle", 32'({busy, hi, lo}), 32'h0);
    $display("mid_run_reset: busy=%0b hi=%h lo=%h", busy, hi, lo);
    run_op("mult_after_rst", 1'b0, 16'h1234, 16'h5678, 16'h0626, 16'h0060, 1'b0, OV_EN, 17);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
